// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues start with operands; the slave side reports status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             br;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  diff,
    input  br
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output diff,
    output br
  );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per SHIFT cycle, LSB first.
// Produces diff = a-b mod 2^WIDTH and the final borrow after WIDTH cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;

  logic             accept;
  logic             last_bit;
  logic             bit_a;
  logic             bit_b;
  logic             half_d;
  logic             d;
  logic             bor_next;
  logic [WIDTH-1:0] res_shifted;

  // A start is only honoured when no subtraction is in flight.
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full subtractor as two cascaded half-subtractors; the difference bit enters the result MSB-first.
  always_comb begin
    bit_a       = a_sr[0];
    bit_b       = b_sr[0];
    half_d      = bit_a ^ bit_b;
    d           = half_d ^ bor;
    bor_next    = (~bit_a & bit_b) | (~half_d & bor);
    res_shifted = {d, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_shifted;
      bor    <= bor_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        diff_q <= res_shifted;
        br_q   <= bor_next;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.br   = br_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 a  input  WIDTH  minuend, unsigned; sampled only when start is accepted.
REQ-007 b  input  WIDTH  subtrahend, unsigned; sampled only when start is accepted.
REQ-008 busy  output  1  high while a subtraction is in progress (state SHIFT).
REQ-009 done  output  1  single-cycle pulse marking a new valid result.
REQ-010 diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
REQ-011 br  output  1  registered final borrow; 1 iff a<b (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE; encoding is free.
REQ-013 Start is accepted only in IDLE or DONE; an accepted start loads a and b into internal shift registers, clears the borrow flip-flop, clears the bit counter, and moves to SHIFT.
REQ-014 start SHALL be ignored in SHIFT; operand shift registers and the counter are unaffected.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first, as a full subtractor built from two half-subtractor steps: d = ai^bi^bor; bor_next = (~ai&bi) | (~(ai^bi)&bor).
REQ-016 The computed d SHALL shift into an internal result register MSB-first so that after WIDTH cycles bit i holds the bit-i difference.
REQ-017 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; diff and br update only on that transition.
REQ-018 Latency: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH, and diff/br are valid in that same cycle.
REQ-019 done SHALL be high for exactly one cycle (the DONE state); DONE goes to IDLE without start, or to SHIFT with start (back-to-back, zero idle cycles).
REQ-020 diff and br SHALL hold their last value in IDLE, SHIFT and DONE until the next completion overwrites them.
REQ-021 busy SHALL be 1 in SHIFT only; busy and done are never high together.
REQ-022 The bit counter SHALL be wide enough to count WIDTH and SHALL not wrap during a transaction.
REQ-023 a and b changing during SHIFT SHALL not affect the in-flight result.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, diff=0, br=0, counter=0, borrow=0, operand registers=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; diff/br read 0.
REQ-026 After rst_n deasserts, the first start may be accepted on the first rising clk edge.

Verification
REQ-027 WIDTH=8, a=0x5A, b=0x3C, start one cycle -> busy for 8 cycles, done pulse after, diff=0x1E, br=0.
REQ-028 a=0x00, b=0x01 -> diff=0xFF, br=1; a=0xFF, b=0xFF -> diff=0x00, br=0; a=0x80, b=0x7F -> diff=0x01, br=0.
REQ-029 start re-pulsed with a=0x11,b=0x22 during SHIFT of 0x5A-0x3C -> ignored, result still 0x1E/0, single done pulse.
REQ-030 start held high in DONE cycle with a=0x10,b=0x20 -> next SHIFT begins immediately, second done 9 cycles after first, diff=0xF0, br=1.
REQ-031 rst_n pulsed low at SHIFT cycle 4 -> busy=0, diff=0, br=0 asynchronously, no done; subsequent 0x03-0x01 returns 0x02, br=0.
REQ-032 Random regression, WIDTH=8 and WIDTH=16, 1000 operations each -> diff==(a-b) mod 2^WIDTH and br==(a<b) on every done.
